// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: write-back controls, ID read ports and forwarding outputs.
// The master drives the pipeline-register fields and read indices; the slave returns data.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [1:0]            CTR_bits;
    logic [DATA_WIDTH-1:0] Read_data;
    logic [DATA_WIDTH-1:0] mem_ALU_result;
    logic [ADDR_WIDTH-1:0] mem_Write_reg;
    logic [ADDR_WIDTH-1:0] Read_reg1;
    logic [ADDR_WIDTH-1:0] Read_reg2;
    logic [DATA_WIDTH-1:0] Read_data1;
    logic [DATA_WIDTH-1:0] Read_data2;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_en;
    logic [31:0]           wb_count;

    modport master (
        output CTR_bits, Read_data, mem_ALU_result, mem_Write_reg, Read_reg1, Read_reg2,
        input  Read_data1, Read_data2, wb_data, wb_en, wb_count
    );

    modport slave (
        input  CTR_bits, Read_data, mem_ALU_result, mem_Write_reg, Read_reg1, Read_reg2,
        output Read_data1, Read_data2, wb_data, wb_en, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select plus 2-read/1-write register file with write-through bypass and commit counter.
// Reads and wb_data are combinational, writes land on the clock edge; no backpressure (bubble = CTR_bits 00).
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic        clock,
    input logic        reset,
    wb_regfile_if.slave bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [31:0]           count_q;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_en;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    assign wb_data = bus.CTR_bits[0] ? bus.Read_data : bus.mem_ALU_result;
    assign wb_en   = bus.CTR_bits[1] && (bus.mem_Write_reg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[bus.mem_Write_reg] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (wb_en) begin
            count_q <= count_q + 32'd1;
        end
    end

    // r0 wins over the bypass so a dropped r0 write can never leak through.
    always_comb begin
        rd1 = regs[bus.Read_reg1];
        if (bus.Read_reg1 == '0) begin
            rd1 = '0;
        end else if (wb_en && (bus.Read_reg1 == bus.mem_Write_reg)) begin
            rd1 = wb_data;
        end
    end

    always_comb begin
        rd2 = regs[bus.Read_reg2];
        if (bus.Read_reg2 == '0) begin
            rd2 = '0;
        end else if (wb_en && (bus.Read_reg2 == bus.mem_Write_reg)) begin
            rd2 = wb_data;
        end
    end

    assign bus.Read_data1 = rd1;
    assign bus.Read_data2 = rd2;
    assign bus.wb_data    = wb_data;
    assign bus.wb_en      = wb_en;
    assign bus.wb_count   = count_q;
endmodule
